// File: rtl/saw_pkg.sv
// Shared definitions for the stop-and-wait ARQ link: FSM states, frame field
// positions and the even-parity check used by both transmitter and receiver.
package saw_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    DELIVER = 3'd2,
    ACK     = 3'd3,
    NAK     = 3'd4
  } state_e;

  typedef struct packed {
    state_e state;
    logic   exp_seq;
  } dbg_t;

  localparam int PAR_BIT = 0;

  function automatic int seq_bit(input int bw);
    return bw - 1;
  endfunction

  // Frames are zero-extended into the argument, which leaves parity unchanged.
  function automatic logic parity_ok(input logic [63:0] f);
    return ~(^f);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/saw_receiver.sv
// Stop-and-wait ARQ receiver: parity and sequence check, in-order delivery to a
// valid/ready sink, and an ACK or NAK pulse answering every accepted frame.
module saw_receiver
  import saw_pkg::*;
#(
  parameter int BW    = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BW-1:0]    frame_in,
  input  logic             frame_valid,
  output logic [BW-3:0]    data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             ack,
  output logic             ack_seq,
  output logic             nak,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output dbg_t             dbg_o
);

  localparam int SEQ = seq_bit(BW);

  // Handshake: a payload moves to the sink on a rising edge where data_valid
  // and data_ready are both high; data_out/data_valid hold steady until then.
  state_e        state_q;
  logic [BW-1:0] frame_q;
  logic          exp_seq_q;

  logic par_ok;
  logic seq_match;
  logic err_inc;
  logic dup_inc;

  assign par_ok    = parity_ok(64'(frame_q));
  assign seq_match = (frame_q[SEQ] == exp_seq_q);
  assign err_inc   = (state_q == CHECK) && !par_ok;
  assign dup_inc   = (state_q == CHECK) && par_ok && !seq_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      exp_seq_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_valid) begin
            frame_q <= frame_in;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!par_ok)        state_q <= NAK;
          else if (seq_match) state_q <= DELIVER;
          else                state_q <= ACK;
        end
        DELIVER: begin
          if (data_ready) begin
            exp_seq_q <= ~exp_seq_q;
            state_q   <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        NAK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counters step on the CHECK exit edge so the new count is visible with nak.
  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dup_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dup_inc),
    .count (dup_cnt)
  );

  assign data_out   = frame_q[SEQ-1:PAR_BIT+1];
  assign data_valid = (state_q == DELIVER);
  assign ack        = (state_q == ACK);
  assign ack_seq    = (state_q == ACK) & frame_q[SEQ];
  assign nak        = (state_q == NAK);
  assign busy       = (state_q != IDLE);

  assign dbg_o.state   = state_q;
  assign dbg_o.exp_seq = exp_seq_q;

endmodule

// File: tb/tb_saw_receiver.sv
// Bench for saw_receiver: directed frame table, reset during delivery, error
// counter saturation and random frames against a transaction-level model.
module tb_saw_receiver;
  import saw_pkg::*;

  localparam int BW    = 10;
  localparam int CNT_W = 8;
  localparam int PW    = BW - 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [BW-1:0]    frame_in;
  logic             frame_valid;
  logic [PW-1:0]    data_out;
  logic             data_valid;
  logic             data_ready;
  logic             ack;
  logic             ack_seq;
  logic             nak;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] dup_cnt;
  dbg_t             dbg;

  always #5 clk = ~clk;

  saw_receiver #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ack         (ack),
    .ack_seq     (ack_seq),
    .nak         (nak),
    .busy        (busy),
    .err_cnt     (err_cnt),
    .dup_cnt     (dup_cnt),
    .dbg_o       (dbg)
  );

  typedef struct {
    logic [BW-1:0] frame;
    int            stall;
    int            exp_err;
    int            exp_dup;
    logic          exp_seq;
  } vec_t;

  vec_t   tbl[6];
  state_e exp_q[$];
  int     vectors    = 0;
  int     miscompares = 0;
  int     m_err      = 0;
  int     m_dup      = 0;
  logic   m_exp_seq  = 1'b0;
  int     nak_seen   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of expected outputs for the phase the frame should be in.
  task automatic cmp_cycle(input state_e ph, input logic seq, input logic [PW-1:0] pl);
    logic [63:0] got;
    logic [63:0] exp;
    if (nak === 1'b1) nak_seen++;
    got = 64'({busy, data_valid, ack, nak, ack_seq,
               (ph == DELIVER) ? data_out : {PW{1'b0}},
               err_cnt, dup_cnt, dbg.state, dbg.exp_seq});
    exp = 64'({ph != IDLE, ph == DELIVER, ph == ACK, ph == NAK, (ph == ACK) & seq,
               (ph == DELIVER) ? pl : {PW{1'b0}},
               CNT_W'(m_err), CNT_W'(m_dup), ph, m_exp_seq});
    check({"cycle_", ph.name()}, got, exp);
  endtask

  // Drive stray frames while busy; the receiver must ignore them.
  task automatic junk();
    frame_in    = BW'($urandom);
    frame_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input logic [BW-1:0] f, input int stall);
    logic          seq;
    logic [PW-1:0] pl;
    state_e        outc;
    seq = f[BW-1];
    pl  = f[BW-2:1];
    if (^f)                  outc = NAK;
    else if (seq == m_exp_seq) outc = DELIVER;
    else                     outc = ACK;
    exp_q.delete();
    exp_q.push_back(CHECK);
    if (outc == DELIVER) for (int j = 0; j <= stall; j++) exp_q.push_back(DELIVER);
    exp_q.push_back(outc == NAK ? NAK : ACK);
    exp_q.push_back(IDLE);

    @(posedge clk); #1;
    frame_in = f; frame_valid = 1'b1; data_ready = 1'b0;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    for (int k = 0; exp_q.size() > 0; k++) begin
      state_e ph;
      ph = exp_q.pop_front();
      @(negedge clk);
      if (ph == ACK && outc == DELIVER) m_exp_seq = ~m_exp_seq;
      if (ph == NAK) m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
      if (ph == ACK && outc == ACK) m_dup = (m_dup < CMAX) ? m_dup + 1 : CMAX;
      cmp_cycle(ph, seq, pl);
      if (ph == IDLE) begin
        frame_valid = 1'b0;
      end else begin
        junk();
        data_ready = (ph == DELIVER) && (k == stall + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_in = '0; frame_valid = 1'b0; data_ready = 1'b0;
    tbl[0] = '{10'b0_00101101_0, 0, 0, 0, 1'b1};
    tbl[1] = '{10'b0_00101101_0, 0, 0, 1, 1'b1};
    tbl[2] = '{10'b0_00101101_1, 0, 1, 1, 1'b1};
    tbl[3] = '{10'b1_00101101_1, 5, 1, 1, 1'b0};
    tbl[4] = '{10'b1_00101101_1, 0, 1, 2, 1'b0};
    tbl[5] = '{10'b0_11111111_0, 2, 1, 2, 1'b1};

    #1;
    check("reset_outputs", 64'({busy, data_valid, ack, nak, ack_seq, data_out, err_cnt, dup_cnt, dbg}), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_frame(tbl[i].frame, tbl[i].stall);
      check($sformatf("tbl_counts_%0d", i), 64'({err_cnt, dup_cnt, dbg.exp_seq}),
            64'({CNT_W'(tbl[i].exp_err), CNT_W'(tbl[i].exp_dup), tbl[i].exp_seq}));
    end

    // Reset while a payload is waiting on the sink.
    @(posedge clk); #1;
    frame_in = 10'b1_00000001_0; frame_valid = 1'b1; data_ready = 1'b0;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("deliver_before_rst", 64'({data_valid, data_out}), 64'({1'b1, 8'h01}));
    #1 rst = 1'b1;
    #1;
    check("async_rst_outputs", 64'({busy, data_valid, ack, nak, ack_seq, data_out, err_cnt, dup_cnt, dbg}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    m_err = 0; m_dup = 0; m_exp_seq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_ack_after_rst", 64'({ack, nak, busy}), 64'(0));
    end
    run_frame(10'b0_01010101_0, 1);

    // Saturation of the parity error counter.
    nak_seen = 0;
    for (int n = 0; n < 300; n++) begin
      logic [BW-1:0] f;
      f    = BW'($urandom);
      f[0] = ~(^f[BW-1:1]);
      run_frame(f, 0);
    end
    check("err_cnt_saturated", 64'(err_cnt), 64'(CMAX));
    check("nak_pulses_300", 64'(nak_seen), 64'(300));

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      logic [BW-1:0] f;
      logic [PW-1:0] pl;
      logic          sq;
      int            idx;
      pl = PW'($urandom);
      sq = 1'($urandom_range(0, 1));
      f  = {sq, pl, ^{sq, pl}};
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, BW - 1);
        f[idx] = ~f[idx];
      end
      run_frame(f, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
